// File: rtl/bcd_display_scan_pkg.sv
// Seven-segment constants shared by the display scanner and its decoder.
// Segment bit order is {g,f,e,d,c,b,a}, active-low (0 = segment lit).
// Constants only; no timing or flow-control behaviour.
package bcd_display_scan_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

endpackage

// File: rtl/bcd_to_seg7.sv
// BCD nibble to active-low seven-segment decoder; 10-15 show a dash.
// Purely combinational, zero latency.
// No flow control.
module bcd_to_seg7
    import bcd_display_scan_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (nib)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_display_scan.sv
// Time-multiplexed 7-segment scanner: per-frame BCD snapshot, guard-blanked slots, LZ blanking.
// Outputs registered, one cycle after the slot counter/index they reflect.
// No backpressure; free-running scan, bcd_in sampled only at frame start.
module bcd_display_scan
    import bcd_display_scan_pkg::*;
#(
    parameter int NDIG      = 6,
    parameter int SLOT_CYC  = 50000,
    parameter int GUARD_CYC = 500
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [4*NDIG-1:0]   bcd_in,
    input  logic [NDIG-1:0]     dp_in,
    input  logic                blank_lz,
    output logic [6:0]          seg,
    output logic                dp,
    output logic [NDIG-1:0]     an,
    output logic                frame_start
);

    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int CW = $clog2(SLOT_CYC);

    logic [CW-1:0]      slot_cnt;
    logic [IW-1:0]      idx;
    logic [4*NDIG-1:0]  snap;
    logic [NDIG-1:0]    dp_snap;

    logic               snap_cyc;
    logic               slot_wrap;
    logic               guard;
    logic [NDIG-1:0]    lz_blank;
    logic [NDIG-1:0]    an_sel;
    logic [3:0]         cur_nib;
    logic               cur_dp;
    logic               cur_blank;
    logic [6:0]         dec_seg;

    assign snap_cyc  = (idx == '0) && (slot_cnt == '0);
    assign slot_wrap = (slot_cnt == CW'(SLOT_CYC - 1));
    assign guard     = (slot_cnt < CW'(GUARD_CYC));

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_cnt <= '0;
            idx      <= '0;
            snap     <= '0;
            dp_snap  <= '0;
        end else begin
            slot_cnt <= slot_wrap ? '0 : slot_cnt + 1'b1;
            if (slot_wrap)
                idx <= (idx == IW'(NDIG - 1)) ? '0 : idx + 1'b1;
            if (snap_cyc) begin
                snap    <= bcd_in;
                dp_snap <= dp_in;
            end
        end
    end

    // Walk from the most significant digit down; a digit is a leading zero
    // while every digit from the top down to it (inclusive) is zero.
    always_comb begin
        logic all_zero;
        all_zero = 1'b1;
        lz_blank = '0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            all_zero    = all_zero && (snap[4*i +: 4] == 4'd0);
            lz_blank[i] = blank_lz && (i != 0) && all_zero;
        end
    end

    always_comb begin
        cur_nib   = snap[3:0];
        cur_dp    = dp_snap[0];
        cur_blank = lz_blank[0];
        an_sel    = '1;
        for (int i = 0; i < NDIG; i++) begin
            if (idx == IW'(i)) begin
                cur_nib   = snap[4*i +: 4];
                cur_dp    = dp_snap[i];
                cur_blank = lz_blank[i];
                an_sel[i] = 1'b0;
            end
        end
    end

    bcd_to_seg7 u_dec (
        .nib (cur_nib),
        .seg (dec_seg)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            an          <= '1;
            seg         <= SEG_BLANK;
            dp          <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            frame_start <= snap_cyc;
            if (guard || cur_blank) begin
                an  <= '1;
                seg <= SEG_BLANK;
                dp  <= 1'b1;
            end else begin
                an  <= an_sel;
                seg <= dec_seg;
                dp  <= ~cur_dp;
            end
        end
    end

endmodule
